// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage ARM pipeline.
// Generates operand 2, runs the ALU, computes the branch target and holds NZCV.
// Optional iterative 32-cycle multiplier (MUL, cmd 1010) and stall output,
// enabled by defining the EXE_MUL_EN macro; without it busy is tied low.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [3:0]  exe_cmd,
  input  logic        b,
  input  logic        s,
  input  logic [31:0] pc,
  input  logic [31:0] value_rn,
  input  logic [31:0] value_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic [23:0] imm_signed_24,
  input  logic [3:0]  dest_in,
  output logic [31:0] alu_result,
  output logic [31:0] br_addr,
  output logic        b_taken,
  output logic [3:0]  status,
  output logic        busy,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [3:0]  dest,
  output logic [31:0] store_val
);
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
`ifdef EXE_MUL_EN
  localparam logic [3:0] CMD_MUL = 4'b1010;
`endif

  logic [31:0] val2, shifted, rot_imm, opb, res;
  logic [63:0] rm_dbl, imm_dbl;
  logic [4:0]  sh_amt;
  logic [32:0] sum;
  logic        cin, is_sub, arith, cmd_defined;
  logic [3:0]  status_q, status_d;
  logic        mul_done;
  logic [31:0] mul_res;

  // Operand 2: memory offset, rotated immediate or shifted register.
  always_comb begin
    sh_amt  = shift_operand[11:7];
    rm_dbl  = {value_rm, value_rm};
    imm_dbl = {2{24'd0, shift_operand[7:0]}};
    rot_imm = 32'(imm_dbl >> {shift_operand[11:8], 1'b0});
    unique case (shift_operand[6:5])
      2'b00:   shifted = value_rm << sh_amt;
      2'b01:   shifted = value_rm >> sh_amt;
      2'b10:   shifted = $unsigned($signed(value_rm) >>> sh_amt);
      default: shifted = 32'(rm_dbl >> sh_amt);
    endcase
    if (mem_r_en_in | mem_w_en_in) val2 = {20'd0, shift_operand};
    else if (imm)                  val2 = rot_imm;
    else                           val2 = shifted;
  end

  // ALU and next flags; subtract is rn + ~val2 + carry-in so C is NOT borrow.
  always_comb begin
    is_sub = (exe_cmd == CMD_SUB) || (exe_cmd == CMD_SBC);
    opb    = is_sub ? ~val2 : val2;
    unique case (exe_cmd)
      CMD_ADC, CMD_SBC: cin = status_q[1];
      CMD_SUB:          cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sum         = {1'b0, value_rn} + {1'b0, opb} + {32'd0, cin};
    res         = '0;
    arith       = 1'b0;
    cmd_defined = 1'b1;
    unique case (exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        res   = sum[31:0];
        arith = 1'b1;
      end
      CMD_AND: res = value_rn & val2;
      CMD_ORR: res = value_rn | val2;
      CMD_EOR: res = value_rn ^ val2;
`ifdef EXE_MUL_EN
      CMD_MUL: res = mul_done ? mul_res : 32'd0;
`endif
      default: cmd_defined = 1'b0;
    endcase
    status_d = {res[31], (res == 32'd0), status_q[1:0]};
    if (arith) begin
      status_d[1] = sum[32];
      status_d[0] = (value_rn[31] == opb[31]) && (sum[31] != value_rn[31]);
    end
  end

  // NZCV register: only defined, non-stalled commands with s set update it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           status_q <= '0;
    else if (s && !busy && cmd_defined) status_q <= status_d;
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_e;
  mstate_e     st_q, st_d;
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  // Multiplier state and shift-add datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= M_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      st_q     <= st_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: load on MUL detect, one shift-add step per RUN cycle.
  always_comb begin
    st_d     = st_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (st_q)
      M_IDLE: if (exe_cmd == CMD_MUL) begin
        st_d     = M_RUN;
        mcand_d  = value_rn;
        mplier_d = value_rm;
        acc_d    = '0;
        cnt_d    = '0;
      end
      M_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) st_d = M_DONE;
      end
      M_DONE:  st_d = M_IDLE;
      default: st_d = M_IDLE;
    endcase
  end

  // Outputs: stall from MUL detect through the last RUN cycle.
  always_comb begin
    busy     = ((st_q == M_IDLE) && (exe_cmd == CMD_MUL)) || (st_q == M_RUN);
    mul_done = (st_q == M_DONE);
    mul_res  = acc_q;
  end
`else
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  assign alu_result = res;
  assign br_addr    = pc + {{6{imm_signed_24[23]}}, imm_signed_24, 2'b00};
  assign b_taken    = b;
  assign status     = status_q;
  assign wb_en      = wb_en_in;
  assign mem_r_en   = mem_r_en_in;
  assign mem_w_en   = mem_w_en_in;
  assign dest       = dest_in;
  assign store_val  = value_rm;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage with a behavioural reference model.
module tb_exe_stage;
`ifdef EXE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wb_en_in, mem_r_en_in, mem_w_en_in, b, s, imm;
  logic [3:0]  exe_cmd, dest_in;
  logic [31:0] pc, value_rn, value_rm;
  logic [11:0] shift_operand;
  logic [23:0] imm_signed_24;
  logic [31:0] alu_result, br_addr, store_val;
  logic        b_taken, busy, wb_en, mem_r_en, mem_w_en;
  logic [3:0]  status, dest;

  exe_stage dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .exe_cmd(exe_cmd), .b(b), .s(s), .pc(pc),
    .value_rn(value_rn), .value_rm(value_rm), .shift_operand(shift_operand),
    .imm(imm), .imm_signed_24(imm_signed_24), .dest_in(dest_in),
    .alu_result(alu_result), .br_addr(br_addr), .b_taken(b_taken),
    .status(status), .busy(busy), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .dest(dest), .store_val(store_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res, br, sv;
    logic        bt, wb, mr, mw;
    logic [3:0]  st, dst;
    int          busy_cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_cmp = 0, n_bad = 0, bcnt = 0;
  logic       mon_en = 1'b0;
  logic [3:0] m_st;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operand 2 from the ISA rules, one bit-step at a time.
  function automatic logic [31:0] m_val2(input logic mem, input logic im,
                                         input logic [11:0] so, input logic [31:0] rm);
    logic [31:0] x;
    if (mem) return {20'd0, so};
    if (im) begin
      x = {24'd0, so[7:0]};
      for (int i = 0; i < 2 * int'(so[11:8]); i++) x = {x[0], x[31:1]};
      return x;
    end
    x = rm;
    for (int i = 0; i < int'(so[11:7]); i++)
      case (so[6:5])
        2'd0:    x = x * 2;
        2'd1:    x = x / 2;
        2'd2:    x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    return x;
  endfunction

  // Instruction semantics with exact 64-bit arithmetic for carry/overflow.
  function automatic void m_exec(input logic [3:0] cmd, input logic [31:0] rn,
                                 input logic [31:0] v2, input logic [31:0] rm,
                                 input logic s_i, inout logic [3:0] f,
                                 output logic [31:0] r);
    longint u, sg, ci;
    logic   upd, c, v;
    upd = 1'b1; c = f[1]; v = f[0]; r = '0;
    case (cmd)
      4'd1: r = v2;
      4'd9: r = ~v2;
      4'd6: r = rn & v2;
      4'd7: r = rn | v2;
      4'd8: r = rn ^ v2;
      4'd2, 4'd3: begin
        ci = (cmd == 4'd3) ? longint'(f[1]) : 0;
        u  = longint'(rn) + longint'(v2) + ci;
        sg = longint'($signed(rn)) + longint'($signed(v2)) + ci;
        r  = u[31:0];
        c  = (u != longint'(r));
        v  = (sg != longint'($signed(r)));
      end
      4'd4, 4'd5: begin
        ci = (cmd == 4'd5) ? longint'(!f[1]) : 0;
        u  = longint'(rn) - longint'(v2) - ci;
        sg = longint'($signed(rn)) - longint'($signed(v2)) - ci;
        r  = u[31:0];
        c  = (u >= 0);
        v  = (sg != longint'($signed(r)));
      end
      4'd10: if (MUL_EN) r = rn * rm; else upd = 1'b0;
      default: upd = 1'b0;
    endcase
    if (s_i && upd) f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Drive one instruction, push its expected response, hold it while it occupies EX.
  task automatic issue(input logic [3:0] cmd, input logic s_i, input logic b_i,
                       input logic [31:0] pc_i, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] so, input logic im, input logic [23:0] off,
                       input logic mr, input logic mw, input logic wb, input logic [3:0] d);
    exp_t        e;
    logic [31:0] v2, r;
    exe_cmd = cmd; s = s_i; b = b_i; pc = pc_i; value_rn = rn; value_rm = rm;
    shift_operand = so; imm = im; imm_signed_24 = off;
    mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = wb; dest_in = d;
    v2 = m_val2(mr | mw, im, so, rm);
    e.st = m_st;
    m_exec(cmd, rn, v2, rm, s_i, m_st, r);
    e.res = r;
    e.br  = pc_i + 32'(int'($signed(off)) * 4);
    e.bt  = b_i; e.wb = wb; e.mr = mr; e.mw = mw; e.dst = d; e.sv = rm;
    e.busy_cyc = (MUL_EN && cmd == 4'd10) ? 33 : 0;
    sb_q.push_back(e);
    repeat (e.busy_cyc + 1) @(posedge clk);
    #1;
  endtask

  // Monitor: count stall cycles, compare when the stage presents a result.
  always @(negedge clk) begin
    if (!mon_en) bcnt = 0;
    else if (busy) begin
      bcnt++;
      if (bcnt == 40) begin
        n_cmp++; n_bad++;
        $display("FAIL busy_timeout: busy still high after %0d cycles, expected at most 33", bcnt);
      end
    end else if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("alu_result", alu_result, mon_e.res);
      chk("br_addr", br_addr, mon_e.br);
      chk("b_taken", 32'(b_taken), 32'(mon_e.bt));
      chk("status", 32'(status), 32'(mon_e.st));
      chk("wb_en", 32'(wb_en), 32'(mon_e.wb));
      chk("mem_r_en", 32'(mem_r_en), 32'(mon_e.mr));
      chk("mem_w_en", 32'(mem_w_en), 32'(mon_e.mw));
      chk("dest", 32'(dest), 32'(mon_e.dst));
      chk("store_val", store_val, mon_e.sv);
      chk("busy_cycles", 32'(bcnt), 32'(mon_e.busy_cyc));
      bcnt = 0;
    end
  end

  task automatic drain(input string nm);
    @(negedge clk);
    mon_en = 1'b0;
    chk(nm, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] rc;
    logic       mem;
    rst = 1'b1; exe_cmd = '0; s = 0; b = 0; pc = '0; value_rn = '0; value_rm = '0;
    shift_operand = '0; imm = 0; imm_signed_24 = '0; mem_r_en_in = 0; mem_w_en_in = 0;
    wb_en_in = 0; dest_in = '0; m_st = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0; mon_en = 1'b1;

    // Directed cases: overflow add, SUB then AND holding C, operand-2 forms, branch, MUL.
    issue(4'd2, 1, 0, 32'h0, 32'h7FFFFFFF, 32'h1, 12'h000, 0, 24'h0, 0, 0, 1, 4'd3);
    issue(4'd4, 1, 0, 32'h0, 32'd5, 32'd5, 12'h000, 0, 24'h0, 0, 0, 1, 4'd4);
    issue(4'd6, 1, 0, 32'h0, 32'h1F, 32'h10, 12'h000, 0, 24'h0, 0, 0, 1, 4'd5);
    issue(4'd1, 0, 0, 32'h0, 32'h0, 32'h0, 12'hF01, 1, 24'h0, 0, 0, 1, 4'd6);
    issue(4'd1, 0, 0, 32'h0, 32'h0, 32'hF1, 12'h260, 0, 24'h0, 0, 0, 1, 4'd7);
    issue(4'd0, 0, 1, 32'h100, 32'h0, 32'h0, 12'h000, 0, 24'hFFFFFE, 0, 0, 0, 4'd0);
    issue(4'd2, 1, 0, 32'h0, 32'hFFFFFFFF, 32'h1, 12'h000, 0, 24'h0, 0, 0, 1, 4'd1);
    issue(4'd10, 1, 0, 32'h0, 32'd7, 32'hFFFFFFFF, 12'h000, 0, 24'h0, 0, 0, 1, 4'd2);
    issue(4'd10, 1, 0, 32'h0, 32'd0, 32'h1234, 12'h000, 0, 24'h0, 0, 0, 1, 4'd2);
    issue(4'd0, 0, 0, 32'h0, 32'h0, 32'h0, 12'h000, 0, 24'h0, 0, 0, 0, 4'd0);

    // Randomized instruction stream; MUL kept rare because each holds EX 34 cycles.
    for (int i = 0; i < 200; i++) begin
      rc = 4'($urandom_range(0, 15));
      if (rc == 4'd10 && $urandom_range(0, 3) != 0) rc = 4'd2;
      mem = ($urandom_range(0, 7) == 0);
      issue(rc, 1'($urandom), 1'($urandom), $urandom & 32'hFFFFFFFC, $urandom,
            ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            12'($urandom), 1'($urandom), 24'($urandom),
            mem & 1'($urandom), mem & 1'($urandom), 1'($urandom), 4'($urandom));
    end
    issue(4'd0, 0, 0, 32'h0, 32'h0, 32'h0, 12'h000, 0, 24'h0, 0, 0, 0, 4'd0);
    drain("scoreboard_empty");

    // Reset in the middle of a MUL, then a clean MOV and a fresh MUL.
    exe_cmd = 4'd1; imm = 0; mem_r_en_in = 0; mem_w_en_in = 0; shift_operand = '0;
    value_rm = 32'h80000000; s = 1;
    @(posedge clk); #1;
    chk("pre_reset_n", 32'(status[3]), 32'd1);
    exe_cmd = 4'd10; value_rn = 32'd3; value_rm = 32'd5;
    repeat (11) @(posedge clk); #1;
    chk("mid_mul_busy", 32'(busy), 32'(MUL_EN));
    rst = 1'b1; #1;
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_busy_mul_cmd", 32'(busy), 32'(MUL_EN));
    exe_cmd = 4'd1; value_rm = 32'd0; #1;
    chk("rst_busy_mov", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_mov", alu_result, 32'd0);
    chk("post_rst_status", 32'(status), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_mov_flags", 32'(status), 32'b0100);
    m_st = 4'b0100; mon_en = 1'b1;
    issue(4'd10, 1, 0, 32'h0, 32'd6, 32'd7, 12'h000, 0, 24'h0, 0, 0, 1, 4'd9);
    issue(4'd0, 0, 0, 32'h0, 32'h0, 32'h0, 12'h000, 0, 24'h0, 0, 0, 0, 4'd0);
    drain("scoreboard_empty_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
